// File: rtl/count_stream_checker_if.sv
// count_stream_checker_if: observed counter bus (count, enable, reset)
//   cnt_rst : counter reset as driven to the counter (active-high)
//   cnt_en  : counter enable
//   count   : counter output, WIDTH bits
//   master  : drives the bus (counter or bench); slave: passive observer
interface count_stream_checker_if #(parameter int WIDTH = 4);
    logic             cnt_rst;
    logic             cnt_en;
    logic [WIDTH-1:0] count;
    modport master (output cnt_rst, cnt_en, count);
    modport slave  (input  cnt_rst, cnt_en, count);
endinterface

// File: rtl/count_stream_checker.sv
// count_stream_checker: passive monitor predicting each count from the previous sample
//   clk        : system clock, rising edge
//   rst        : synchronous active-low reset
//   clear      : synchronous clear of error state, restarts acquisition
//   cif        : observed counter bus (slave modport)
//   locked     : high while tracking
//   mismatch   : one-cycle pulse per failed prediction while tracking
//   sticky_err : set by any mismatch, held until clear or rst
//   err_count  : saturating mismatch count
//   wrap       : one-cycle pulse on a correct max-to-zero step while tracking
//   exp_count  : last prediction made
module count_stream_checker #(
    parameter int WIDTH        = 4,
    parameter int LOCK_SAMPLES = 2,
    parameter int ERR_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    count_stream_checker_if.slave  cif,
    output logic                   locked,
    output logic                   mismatch,
    output logic                   sticky_err,
    output logic [ERR_W-1:0]       err_count,
    output logic                   wrap,
    output logic [WIDTH-1:0]       exp_count
);
    typedef enum logic {ACQUIRE, TRACK} state_t;

    state_t           state_q, state_d;
    logic [3:0]       match_q, match_d;
    logic             have_prev;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en, prev_rst;
    logic [WIDTH-1:0] pred, exp_d;
    logic             hit, mis_d, wrap_d, sticky_d;
    logic [ERR_W-1:0] err_d;

    assign locked = (state_q == TRACK);
    assign pred   = prev_rst ? '0 : prev_en ? prev_count + 1'b1 : prev_count;

    always_comb begin
        // written as an if so an unknown count resolves to a miss
        hit = 1'b0;
        if (cif.count == pred) hit = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        mis_d    = 1'b0;
        wrap_d   = 1'b0;
        sticky_d = sticky_err;
        err_d    = err_count;
        exp_d    = exp_count;
        if (have_prev) begin
            exp_d = pred;
            if (state_q == ACQUIRE) begin
                match_d = hit ? match_q + 4'd1 : 4'd0;
                if (hit && (match_q + 4'd1 == 4'(LOCK_SAMPLES))) begin
                    state_d = TRACK;
                    match_d = 4'd0;
                end
            end else begin
                mis_d  = !hit;
                wrap_d = hit && prev_en && !prev_rst && (&prev_count);
                if (!hit) begin
                    sticky_d = 1'b1;
                    err_d    = (&err_count) ? err_count : err_count + 1'b1;
                end
            end
        end
        // clear wins over any event on the same edge; sampling continues
        if (clear) begin
            state_d  = ACQUIRE;
            match_d  = 4'd0;
            mis_d    = 1'b0;
            wrap_d   = 1'b0;
            sticky_d = 1'b0;
            err_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ACQUIRE;
            match_q    <= 4'd0;
            have_prev  <= 1'b0;
            prev_count <= '0;
            prev_en    <= 1'b0;
            prev_rst   <= 1'b0;
            mismatch   <= 1'b0;
            wrap       <= 1'b0;
            sticky_err <= 1'b0;
            err_count  <= '0;
            exp_count  <= '0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            have_prev  <= 1'b1;
            prev_count <= cif.count;
            prev_en    <= cif.cnt_en;
            prev_rst   <= cif.cnt_rst;
            mismatch   <= mis_d;
            wrap       <= wrap_d;
            sticky_err <= sticky_d;
            err_count  <= err_d;
            exp_count  <= exp_d;
        end
    end
endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker: directed and randomized checks against a sample-history model
module tb_count_stream_checker;
    localparam int LOCK = 2;

    logic clk = 1'b0;
    logic rst, clear;
    count_stream_checker_if #(.WIDTH(4)) cif ();

    logic       a_locked, a_mis, a_sticky, a_wrap;
    logic [7:0] a_err;
    logic [3:0] a_exp;
    logic       b_locked, b_mis, b_sticky, b_wrap;
    logic [1:0] b_err;
    logic [3:0] b_exp;

    int n_checks = 0;
    int n_fail   = 0;

    count_stream_checker #(.WIDTH(4), .LOCK_SAMPLES(LOCK), .ERR_W(8)) u8 (
        .clk(clk), .rst(rst), .clear(clear), .cif(cif),
        .locked(a_locked), .mismatch(a_mis), .sticky_err(a_sticky),
        .err_count(a_err), .wrap(a_wrap), .exp_count(a_exp));

    count_stream_checker #(.WIDTH(4), .LOCK_SAMPLES(LOCK), .ERR_W(2)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .cif(cif),
        .locked(b_locked), .mismatch(b_mis), .sticky_err(b_sticky),
        .err_count(b_err), .wrap(b_wrap), .exp_count(b_exp));

    always #5 clk = ~clk;

    // model: history of the last sample plus a streak/tracking/error tally
    bit m_have, m_pe, m_pr, m_track, m_mis, m_wrap, m_sticky;
    int m_pc, m_streak, m_errs, m_exp;

    task automatic model(input logic r, input logic c, input logic cr, input logic ce, input logic [3:0] v);
        int p;
        bit ok;
        if (!r) begin
            m_have = 0; m_pe = 0; m_pr = 0; m_track = 0; m_mis = 0; m_wrap = 0;
            m_sticky = 0; m_pc = 0; m_streak = 0; m_errs = 0; m_exp = 0;
            return;
        end
        m_mis = 0;
        m_wrap = 0;
        if (m_have) begin
            p = m_pr ? 0 : (m_pe ? (m_pc + 1) % 16 : m_pc);
            m_exp = p;
            ok = (int'(v) == p);
            if (!m_track) begin
                m_streak = ok ? m_streak + 1 : 0;
                if (m_streak == LOCK) begin
                    m_track = 1;
                    m_streak = 0;
                end
            end else begin
                if (!ok) begin
                    m_mis = 1;
                    m_sticky = 1;
                    m_errs++;
                end
                m_wrap = ok && m_pe && !m_pr && m_pc == 15;
            end
        end
        if (c) begin
            m_track = 0; m_streak = 0; m_errs = 0; m_sticky = 0; m_mis = 0; m_wrap = 0;
        end
        m_pc = int'(v);
        m_pe = ce;
        m_pr = cr;
        m_have = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic cr, input logic ce, input logic [3:0] v);
        rst = r;
        clear = c;
        cif.cnt_rst = cr;
        cif.cnt_en = ce;
        cif.count = v;
        @(posedge clk);
        model(r, c, cr, ce, v);
        #1;
        chk("locked", a_locked, m_track);
        chk("mismatch", a_mis, m_mis);
        chk("sticky", a_sticky, m_sticky);
        chk("err8", a_err, (m_errs > 255) ? 255 : m_errs);
        chk("wrap", a_wrap, m_wrap);
        chk("exp", a_exp, m_exp);
        chk("locked2", b_locked, m_track);
        chk("mismatch2", b_mis, m_mis);
        chk("sticky2", b_sticky, m_sticky);
        chk("err2", b_err, (m_errs > 3) ? 3 : m_errs);
        chk("wrap2", b_wrap, m_wrap);
        chk("exp2", b_exp, m_exp);
    endtask

    initial begin
        logic [3:0] cur;
        logic cr, ce, c, r;
        rst = 1'b0;
        clear = 1'b0;
        cif.cnt_rst = 1'b0;
        cif.cnt_en = 1'b0;
        cif.count = 4'd0;
        model(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        cyc(0, 0, 0, 1, 4'd0);
        cyc(0, 0, 0, 1, 4'd0);
        chk("reset_locked", a_locked, 0);
        chk("reset_err", a_err, 0);

        cyc(1, 0, 0, 1, 4'd0);
        cyc(1, 0, 0, 1, 4'd1);
        chk("not_yet_locked", a_locked, 0);
        cyc(1, 0, 0, 1, 4'd2);
        chk("lock_third_edge", a_locked, 1);
        for (int i = 3; i <= 15; i++) cyc(1, 0, 0, 1, 4'(i));
        chk("no_wrap_at_15", a_wrap, 0);
        cyc(1, 0, 0, 1, 4'd0);
        chk("wrap_after_0", a_wrap, 1);
        cyc(1, 0, 0, 1, 4'd1);
        chk("wrap_once", a_wrap, 0);

        for (int i = 2; i <= 5; i++) cyc(1, 0, 0, 1, 4'(i));
        cyc(1, 0, 1, 1, 4'd6);
        cyc(1, 0, 0, 1, 4'd0);
        cyc(1, 0, 0, 1, 4'd1);
        cyc(1, 0, 0, 0, 4'd2);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 4'd2);
        chk("hold_exp", a_exp, 2);
        chk("hold_no_err", a_err, 0);

        cyc(1, 0, 0, 1, 4'd2);
        for (int i = 3; i <= 7; i++) cyc(1, 0, 0, 1, 4'(i));
        cyc(1, 0, 0, 1, 4'd12);
        chk("glitch_out", a_mis, 1);
        cyc(1, 0, 0, 1, 4'd9);
        chk("glitch_back", a_mis, 1);
        cyc(1, 0, 0, 1, 4'd10);
        chk("glitch_err", a_err, 2);
        chk("glitch_locked", a_locked, 1);

        cyc(1, 0, 0, 1, 4'd13);
        cyc(1, 0, 0, 1, 4'd14);
        cyc(1, 0, 0, 1, 4'd0);
        cyc(1, 0, 0, 1, 4'd5);
        chk("sat_err2", b_err, 3);
        chk("sat_err8", a_err, 5);
        cyc(1, 1, 0, 1, 4'd6);
        chk("clear_err", b_err, 0);
        chk("clear_locked", a_locked, 0);
        cyc(1, 0, 0, 1, 4'd7);
        cyc(1, 0, 0, 1, 4'd8);
        chk("relock", a_locked, 1);

        cur = 4'd9;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) != 0);
            c  = ($urandom_range(0, 49) == 0);
            cr = ($urandom_range(0, 15) == 0);
            ce = ($urandom_range(0, 3) != 0);
            cyc(r, c, cr, ce, ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : cur);
            cur = cr ? 4'd0 : (ce ? cur + 4'd1 : cur);
        end

        cyc(1, 0, 0, 1, 4'd0);
        cyc(1, 0, 0, 1, 4'd1);
        cyc(1, 0, 0, 1, 4'd2);
        cyc(1, 0, 0, 1, 4'd3);
        chk("pre_rst_locked", a_locked, 1);
        cyc(0, 0, 0, 1, 4'd11);
        chk("rst_mid_mis", a_mis, 0);
        chk("rst_mid_locked", a_locked, 0);
        cyc(1, 0, 0, 1, 4'd7);
        chk("first_after_rst_exp", a_exp, 0);
        chk("first_after_rst_mis", a_mis, 0);
        cyc(1, 0, 0, 1, 4'd8);
        cyc(1, 0, 0, 1, 4'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
